// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM request controller: FSM states and response buffer depth.
package ram_ctrl_pkg;

  localparam int unsigned RSP_DEPTH = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrlState_e;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small response FIFO holding read data returned by the RAM until the consumer takes it.
module ram_rsp_fifo #(
  parameter int unsigned DATAWIDTH = 2,
  parameter int unsigned RSP_DEPTH = 3,
  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1,
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1)
) (
  input  logic                 PortAClk,
  input  logic                 PortARst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] pushData,
  input  logic                 pop,
  output logic [DATAWIDTH-1:0] popData,
  output logic                 popValid,
  output logic [CntW-1:0]      count
);

  logic [DATAWIDTH-1:0] mem [RSP_DEPTH];
  logic [PtrW-1:0]      wrPtrQ, rdPtrQ;
  logic [CntW-1:0]      countQ, countD;
  logic                 popEn;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign popValid = (countQ != '0);
  assign popEn    = pop & popValid;
  assign count    = countQ;
  // Output forced to zero when empty so reset and idle show a clean bus.
  assign popData  = popValid ? mem[rdPtrQ] : '0;

  always_comb begin
    countD = countQ + CntW'(push) - CntW'(popEn);
  end

  always_ff @(posedge PortAClk or posedge PortARst) begin
    if (PortARst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (push)  wrPtrQ <= incPtr(wrPtrQ);
      if (popEn) rdPtrQ <= incPtr(rdPtrQ);
      countQ <= countD;
    end
  end

  always_ff @(posedge PortAClk) begin
    if (push) mem[wrPtrQ] <= pushData;
  end

endmodule

// File: rtl/ram_req_ctrl.sv
// Request/response front end for a single-port RAM with registered read data.
// Optional power-up RAM clear enabled by defining RAM_REQ_CTRL_INIT_EN.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 2,
  parameter int unsigned ADDRWIDTH = 2
) (
  input  logic                 PortAClk,
  input  logic                 PortARst,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDRWIDTH-1:0] ReqAddr,
  input  logic [DATAWIDTH-1:0] ReqData,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [DATAWIDTH-1:0] RspData,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDataIn,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  ctrlState_e      stateQ;
  logic [CntW-1:0] rspCount;
  logic [CntW:0]   occupancy;
  logic            inflightQ;
  logic            fire;

  // Reserve a FIFO slot for the read still in the RAM pipeline.
  assign occupancy = {1'b0, rspCount} + (CntW + 1)'(inflightQ);
  assign ReqReady  = ~PortARst & (stateQ == RUN) & (occupancy < (CntW + 1)'(RSP_DEPTH));
  assign fire      = ReqValid & ReqReady;

`ifdef RAM_REQ_CTRL_INIT_EN
  logic [ADDRWIDTH-1:0] initCntQ;
  logic                 initWr;

  assign initWr         = ~PortARst & (stateQ == INIT);
  assign RamAddr        = initWr ? initCntQ : ReqAddr;
  assign RamDataIn      = initWr ? '0 : ReqData;
  assign RamWriteEnable = initWr | (fire & ReqWrite);

  always_ff @(posedge PortAClk or posedge PortARst) begin
    if (PortARst) begin
      stateQ   <= INIT;
      initCntQ <= '0;
    end else if (stateQ == INIT) begin
      initCntQ <= initCntQ + 1'b1;
      if (&initCntQ) stateQ <= RUN;
    end
  end
`else
  assign stateQ         = RUN;
  assign RamAddr        = ReqAddr;
  assign RamDataIn      = ReqData;
  assign RamWriteEnable = fire & ReqWrite;
`endif

  always_ff @(posedge PortAClk or posedge PortARst) begin
    if (PortARst) inflightQ <= 1'b0;
    else          inflightQ <= fire & ~ReqWrite;
  end

  ram_rsp_fifo #(
    .DATAWIDTH(DATAWIDTH),
    .RSP_DEPTH(RSP_DEPTH)
  ) uRspFifo (
    .PortAClk(PortAClk),
    .PortARst(PortARst),
    .push    (inflightQ),
    .pushData(RamDataOut),
    .pop     (RspReady),
    .popData (RspData),
    .popValid(RspValid),
    .count   (rspCount)
  );

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl with a behavioural registered-read RAM and a response scoreboard.
module tb_ram_req_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          PortAClk = 1'b0;
  logic          PortARst = 1'b1;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic          ReqWrite = 1'b0;
  logic [AW-1:0] ReqAddr  = '0;
  logic [DW-1:0] ReqData  = '0;
  logic          RspValid;
  logic          RspReady = 1'b1;
  logic [DW-1:0] RspData;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDataIn;
  logic          RamWriteEnable;
  logic [DW-1:0] RamDataOut;

  always #5 PortAClk = ~PortAClk;

  ram_req_ctrl #(
    .DATAWIDTH(DW),
    .ADDRWIDTH(AW)
  ) dut (
    .PortAClk      (PortAClk),
    .PortARst      (PortARst),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqWrite      (ReqWrite),
    .ReqAddr       (ReqAddr),
    .ReqData       (ReqData),
    .RspValid      (RspValid),
    .RspReady      (RspReady),
    .RspData       (RspData),
    .RamAddr       (RamAddr),
    .RamDataIn     (RamDataIn),
    .RamWriteEnable(RamWriteEnable),
    .RamDataOut    (RamDataOut)
  );

  // Registered-read RAM: output updates on non-write cycles, holds during writes.
  logic [DW-1:0] ram [16];
  logic [DW-1:0] ramOut = '0;
  assign RamDataOut = ramOut;
  initial for (int i = 0; i < 16; i++) ram[i] = '0;
  always @(posedge PortAClk) begin
    if (RamWriteEnable) ram[RamAddr] <= RamDataIn;
    else                ramOut <= ram[RamAddr];
  end

  int            nChecks = 0;
  int            nPass   = 0;
  logic [DW-1:0] expQ [$];
  bit            monOn   = 1'b0;
  logic [DW-1:0] monExp;
  logic [DW-1:0] shadow [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge PortAClk) begin
    if (monOn) begin
      if (RspValid && RspReady) begin
        if (expQ.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          monExp = expQ.pop_front();
          check("rsp_data", RspData, monExp);
        end
      end
      check("ram_we_gate", RamWriteEnable, ReqValid & ReqReady & ReqWrite);
    end
  end

  task automatic tick();
    @(posedge PortAClk);
    #1;
  endtask

  task automatic idle();
    ReqValid = 1'b0;
    ReqWrite = 1'b0;
  endtask

  task automatic doOp(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] e, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = a;
    ReqData  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge PortAClk);
      if (ReqReady) begin
        if (!wr) expQ.push_back(e);
        done = 1'b1;
      end else begin
        stalls++;
      end
      tick();
    end
    if (!done) begin
      check("req_timeout", 32'd0, 32'd1);
      ReqValid = 1'b0;
    end
  endtask

  task automatic releaseRst();
    PortARst = 1'b0;
`ifdef RAM_REQ_CTRL_INIT_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge PortAClk);
      check("init_we", RamWriteEnable, 32'd1);
      check("init_addr", RamAddr, i);
      check("init_data", RamDataIn, 32'd0);
      check("init_ready", ReqReady, 32'd0);
      tick();
    end
`endif
    @(negedge PortAClk);
    check("ready_after_release", ReqReady, 32'd1);
    monOn = 1'b1;
    tick();
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int st;
    int stallSum;
    int accepted;
    int seen;
    int acc;

    vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
    vecs[1] = '{1'b1, 4'd5,  8'h3C, 8'h00};
    vecs[2] = '{1'b0, 4'd5,  8'h00, 8'h3C};
    vecs[3] = '{1'b0, 4'd3,  8'h00, 8'hA5};
    vecs[4] = '{1'b1, 4'd0,  8'h11, 8'h00};
    vecs[5] = '{1'b1, 4'd15, 8'hFF, 8'h00};
    vecs[6] = '{1'b0, 4'd15, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 4'd0,  8'h00, 8'h11};
    vecs[8] = '{1'b0, 4'd9,  8'h00, 8'h00};

    // Reset state, with a write request held to prove the RAM port is gated.
    ReqValid = 1'b1;
    ReqWrite = 1'b1;
    repeat (3) tick();
    @(negedge PortAClk);
    check("rst_rspvalid", RspValid, 32'd0);
    check("rst_reqready", ReqReady, 32'd0);
    check("rst_we", RamWriteEnable, 32'd0);
    check("rst_rspdata", RspData, 32'd0);
    tick();
    idle();
    releaseRst();

    // Table-driven back-to-back ops with RspReady high.
    foreach (vecs[i]) doOp(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp, st);
    idle();
    repeat (5) tick();

    // Exact two-cycle read latency.
    doOp(1'b1, 4'd3, 8'hA5, 8'h00, st);
    doOp(1'b0, 4'd3, 8'h00, 8'hA5, st);
    idle();
    @(negedge PortAClk);
    check("lat_t1_valid", RspValid, 32'd0);
    tick();
    @(negedge PortAClk);
    check("lat_t2_valid", RspValid, 32'd1);
    check("lat_t2_data", RspData, 32'h0A5);
    tick();
    repeat (3) tick();

    // Write then read next cycle; only one response in total.
    doOp(1'b1, 4'd5, 8'h3C, 8'h00, st);
    doOp(1'b0, 4'd5, 8'h00, 8'h3C, st);
    idle();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PortAClk);
      if (RspValid) seen++;
      tick();
    end
    check("wr_rd_one_rsp", seen, 32'd1);

    // Sixteen back-to-back reads must never stall.
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 8'(i * 7 + 3);
      doOp(1'b1, 4'(i), shadow[i], 8'h00, st);
    end
    stallSum = 0;
    for (int i = 0; i < 16; i++) begin
      doOp(1'b0, 4'(i), 8'h00, shadow[i], st);
      stallSum += st;
    end
    idle();
    check("b2b_stalls", stallSum, 32'd0);
    repeat (5) tick();
    check("b2b_drained", expQ.size(), 32'd0);

    // Backpressure: three reads accepted, data held, then drained in order.
    RspReady = 1'b0;
    ReqValid = 1'b1;
    ReqWrite = 1'b0;
    acc      = 0;
    ReqAddr  = 4'(acc);
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge PortAClk);
      if (ReqReady) begin
        expQ.push_back(shadow[acc]);
        accepted++;
        acc++;
      end
      tick();
      ReqAddr = 4'(acc);
    end
    check("bp_accepted", accepted, 32'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge PortAClk);
      check("bp_ready_low", ReqReady, 32'd0);
      check("bp_valid", RspValid, 32'd1);
      check("bp_data_held", RspData, shadow[0]);
      tick();
    end
    idle();
    RspReady = 1'b1;
    repeat (6) tick();
    check("bp_drained", expQ.size(), 32'd0);

    // Reset one cycle after a read fire drops the in-flight read.
    doOp(1'b0, 4'd7, 8'h00, shadow[7], st);
    PortARst = 1'b1;
    monOn    = 1'b0;
    idle();
    @(negedge PortAClk);
    check("mid_rst_valid", RspValid, 32'd0);
    check("mid_rst_ready", ReqReady, 32'd0);
    check("mid_rst_data", RspData, 32'd0);
    expQ.delete();
    tick();
    tick();
    releaseRst();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PortAClk);
      if (RspValid) seen++;
      tick();
    end
    check("post_rst_no_rsp", seen, 32'd0);

`ifdef RAM_REQ_CTRL_INIT_EN
    // Address 9 was cleared by the init sweep after the last reset.
    doOp(1'b0, 4'd9, 8'h00, 8'h00, st);
    idle();
    repeat (4) tick();
`endif

    check("final_queue_empty", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", nPass, nChecks);
    $fatal(1);
  end

endmodule
